// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, result tag, FSM states and edge helper for the SPI command engine.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_CS_LOW  = 8'h01;
    localparam logic [7:0] OP_CS_HIGH = 8'h02;
    localparam logic [7:0] OP_WRITE   = 8'h03;
    localparam logic [7:0] OP_XFER    = 8'h04;
    localparam logic [7:0] OP_DELAY   = 8'h05;
    localparam logic [7:0] ERR_TAG    = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        SHIFT = 3'd3,
        DELAY = 3'd4,
        PUSH  = 3'd5
    } state_t;

    // Edges are numbered from 1; cpha=0 samples odd edges, cpha=1 samples even edges.
    function automatic logic sample_edge(input logic cpha, input logic odd_edge);
        return cpha ? ~odd_edge : odd_edge;
    endfunction

endpackage

// File: rtl/spi_cmd_engine_clk_tick.sv
// Half-period tick generator: loadable down-counter, one-cycle tick every i_div+1 clocks.
module spi_clk_tick #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_en,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == CNT_ZERO);

    // Preloading before the active phase makes the first tick land a full half-period in.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= CNT_ZERO;
        end else if (i_load) begin
            r_cnt <= i_div;
        end else if (!i_en) begin
            r_cnt <= CNT_ZERO;
        end else if (o_tick) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/spi_cmd_engine.sv
// Command-driven SPI master: pops command words, runs CS/shift/delay operations, pushes results.
module spi_cmd_engine
    import spi_cmd_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cmd_nempty,
    output logic                 cmd_pop,
    input  logic [WIDTH-1:0]     cmd_data,
    input  logic                 res_full,
    output logic                 res_shift,
    output logic [WIDTH-1:0]     res_data,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 cpol,
    input  logic                 cpha,
    output logic                 spi_sck,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic                 spi_cs,
    output logic                 busy
);

    state_t               r_state;
    logic                 r_pop;
    logic                 r_shift;
    logic [WIDTH-1:0]     r_res;
    logic                 r_cs;
    logic                 r_mosi;
    logic                 r_sck;
    logic                 r_busy;
    logic [7:0]           r_op;
    logic [7:0]           r_arg;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_cpol;
    logic                 r_cpha;
    logic [7:0]           r_tx;
    logic [7:0]           r_rx;
    logic [7:0]           r_cnt;
    logic                 r_err;
    logic                 w_en;
    logic                 w_load;
    logic                 w_tick;

    assign w_en   = (r_state == SHIFT) || (r_state == DELAY);
    assign w_load = (r_state == EXEC);

    spi_clk_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (w_en),
        .i_load  (w_load),
        .i_div   (r_div),
        .o_tick  (w_tick)
    );

    // Command sequencer; every output is a register written here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pop   <= 1'b0;
            r_shift <= 1'b0;
            r_res   <= {WIDTH{1'b0}};
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
            r_sck   <= 1'b0;
            r_busy  <= 1'b0;
            r_op    <= 8'h00;
            r_arg   <= 8'h00;
            r_div   <= {DIV_WIDTH{1'b0}};
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_tx    <= 8'h00;
            r_rx    <= 8'h00;
            r_cnt   <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_pop   <= 1'b0;
            r_shift <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sck <= r_cpol;
                    // Holding off while res_shift is high keeps pop and push strobes apart.
                    if (cmd_nempty && !r_shift) begin
                        r_pop   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_sck <= r_cpol;
                    // First FETCH cycle is the pop cycle; the registered FIFO word arrives in the second.
                    if (!r_pop) begin
                        r_op    <= cmd_data[WIDTH-1:WIDTH-8];
                        r_arg   <= cmd_data[7:0];
                        r_div   <= clk_div;
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_sck <= r_cpol;
                    r_cnt <= 8'h00;
                    r_err <= 1'b0;
                    case (r_op)
                        OP_NOP: begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                        OP_CS_LOW: begin
                            r_cs    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                        OP_CS_HIGH: begin
                            r_cs    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                        OP_WRITE, OP_XFER: begin
                            r_rx <= 8'h00;
                            if (!r_cpha) begin
                                r_mosi <= r_arg[7];
                                r_tx   <= {r_arg[6:0], 1'b0};
                            end else begin
                                r_tx   <= r_arg;
                            end
                            r_state <= SHIFT;
                        end
                        OP_DELAY: begin
                            r_state <= DELAY;
                        end
                        default: begin
                            r_err   <= 1'b1;
                            r_state <= PUSH;
                        end
                    endcase
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_sck <= ~r_sck;
                        r_cnt <= r_cnt + 8'd1;
                        if (sample_edge(r_cpha, ~r_cnt[0])) begin
                            r_rx <= {r_rx[6:0], spi_miso};
                        end else if (r_cnt != 8'd15) begin
                            r_mosi <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                        if (r_cnt == 8'd15) begin
                            if (r_op == OP_XFER) begin
                                r_state <= PUSH;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                DELAY: begin
                    r_sck <= r_cpol;
                    if (w_tick) begin
                        if (r_cnt == r_arg) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                PUSH: begin
                    r_sck <= r_cpol;
                    if (!res_full) begin
                        r_shift <= 1'b1;
                        r_res   <= r_err ? {ERR_TAG, r_op} : {OP_XFER, r_rx};
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_pop   = r_pop;
    assign res_shift = r_shift;
    assign res_data  = r_res;
    assign spi_cs    = r_cs;
    assign spi_mosi  = r_mosi;
    assign spi_sck   = r_sck;
    assign busy      = r_busy;

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Scoreboard bench for spi_cmd_engine: FIFO models on both sides, SCK/MOSI monitor, result queue.
module tb_spi_cmd_engine;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_nempty = 1'b0;
    logic        cmd_pop;
    logic [15:0] cmd_data = 16'h0000;
    logic        res_full;
    logic        res_shift;
    logic [15:0] res_data;
    logic [7:0]  clk_div;
    logic        cpol;
    logic        cpha;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs;
    logic        busy;
    logic        loop_en;
    logic        miso_val;

    always #5 clock = ~clock;

    assign spi_miso = loop_en ? spi_mosi : miso_val;

    spi_cmd_engine #(.WIDTH(16), .DIV_WIDTH(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_nempty (cmd_nempty),
        .cmd_pop    (cmd_pop),
        .cmd_data   (cmd_data),
        .res_full   (res_full),
        .res_shift  (res_shift),
        .res_data   (res_data),
        .clk_div    (clk_div),
        .cpol       (cpol),
        .cpha       (cpha),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_cs     (spi_cs),
        .busy       (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] cmd_q[$];
    logic [15:0] exp_q[$];
    int          rd_ptr = 0;
    logic        fifo_pop;

    int          cyc = 0;
    int          edge_cnt = 0;
    int          cs_hi_cnt = 0;
    int          push_cnt = 0;
    int          pop_cnt = 0;
    int          busy_cnt = 0;
    int          adj_viol = 0;
    int          edge_cyc[$];
    int          pop_cyc[$];
    logic [7:0]  mosi_sr = 8'h00;
    logic        prev_sck = 1'b0;
    logic        last_pop = 1'b0;
    logic        last_shift = 1'b0;

    // Command FIFO with a registered output: a pop seen at an edge presents the word just after it.
    always @(posedge clock) begin
        fifo_pop = cmd_pop;
        #1;
        if (fifo_pop && (rd_ptr < cmd_q.size())) begin
            cmd_data = cmd_q[rd_ptr];
            rd_ptr = rd_ptr + 1;
        end
        cmd_nempty = (rd_ptr < cmd_q.size());
    end

    // Bus monitor: SCK edges, the MOSI bit at each sampling edge, strobes and busy time.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        prev_sck <= spi_sck;
        last_pop <= cmd_pop;
        last_shift <= res_shift;
        if (spi_sck != prev_sck) begin
            edge_cnt <= edge_cnt + 1;
            edge_cyc.push_back(cyc);
            if (spi_cs) cs_hi_cnt <= cs_hi_cnt + 1;
            if ((cpha && (edge_cnt % 2 == 1)) || (!cpha && (edge_cnt % 2 == 0)))
                mosi_sr <= {mosi_sr[6:0], spi_mosi};
        end
        if (res_shift) push_cnt <= push_cnt + 1;
        if (cmd_pop) begin
            pop_cnt <= pop_cnt + 1;
            pop_cyc.push_back(cyc);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if ((cmd_pop && last_shift) || (res_shift && last_pop)) adj_viol <= adj_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        tick();
        while (!((rd_ptr == cmd_q.size()) && !busy)) begin
            tick();
            n++;
            if (n > budget) begin
                chk("idle_timeout", {31'd0, busy}, 32'd0);
                return;
            end
        end
    endtask

    task automatic wait_res(input int budget);
        int n = 0;
        while (!res_shift) begin
            tick();
            n++;
            if (n > budget) begin
                chk("res_timeout", {31'd0, res_shift}, 32'd1);
                return;
            end
        end
        chk("res_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) chk("res_data", {16'd0, res_data}, {16'd0, exp_q.pop_front()});
        tick();
    endtask

    int base_edge, base_push, base_pop, base_busy, base_cs;
    logic [2:0] pins_before;

    initial begin
        reset_n = 1'b0; res_full = 1'b0; clk_div = 8'd1; cpol = 1'b0; cpha = 1'b0;
        loop_en = 1'b1; miso_val = 1'b0;
        repeat (3) tick();
        chk("reset_ctrl", {26'd0, cmd_pop, res_shift, spi_cs, spi_mosi, spi_sck, busy}, 32'b001000);
        chk("reset_res_data", {16'd0, res_data}, 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // CS low, loopback XFER of 0xA5, CS high.
        base_edge = edge_cnt; base_push = push_cnt; base_cs = cs_hi_cnt;
        cmd_q.push_back(16'h0100); cmd_q.push_back(16'h04A5); cmd_q.push_back(16'h0200);
        exp_q.push_back(16'h04A5);
        wait_res(400);
        wait_idle(400);
        chk("x1_edges", edge_cnt - base_edge, 32'd16);
        if (edge_cnt - base_edge >= 16)
            chk("x1_span", edge_cyc[base_edge + 15] - edge_cyc[base_edge], 32'd30);
        chk("x1_mosi", {24'd0, mosi_sr}, 32'hA5);
        chk("x1_cs_low_span", cs_hi_cnt - base_cs, 32'd0);
        chk("x1_pushes", push_cnt - base_push, 32'd1);
        chk("x1_cs_end", {31'd0, spi_cs}, 32'd1);

        // Mode 3 with MISO tied high; a NOP first lets the new idle level settle.
        cpol = 1'b1; cpha = 1'b1; loop_en = 1'b0; miso_val = 1'b1;
        cmd_q.push_back(16'h0000);
        wait_idle(100);
        chk("m3_idle_sck", {31'd0, spi_sck}, 32'd1);
        base_edge = edge_cnt;
        cmd_q.push_back(16'h043C);
        exp_q.push_back(16'h04FF);
        wait_res(400);
        wait_idle(400);
        chk("m3_edges", edge_cnt - base_edge, 32'd16);
        chk("m3_mosi", {24'd0, mosi_sr}, 32'h3C);
        chk("m3_sck_end", {31'd0, spi_sck}, 32'd1);

        // Back-pressure: the result waits on res_full and the next command stays queued.
        cpol = 1'b0; cpha = 1'b0; loop_en = 1'b1; res_full = 1'b1;
        base_push = push_cnt; base_pop = pop_cnt;
        cmd_q.push_back(16'h0411); cmd_q.push_back(16'h0000);
        exp_q.push_back(16'h0411);
        repeat (60) tick();
        chk("bp_no_push", push_cnt - base_push, 32'd0);
        chk("bp_one_pop", pop_cnt - base_pop, 32'd1);
        chk("bp_shift_held", {31'd0, res_shift}, 32'd0);
        res_full = 1'b0;
        tick();
        chk("bp_shift_fire", {31'd0, res_shift}, 32'd1);
        if (res_shift && exp_q.size() > 0) chk("bp_res_data", {16'd0, res_data}, {16'd0, exp_q.pop_front()});
        wait_idle(100);
        chk("bp_pops_after", pop_cnt - base_pop, 32'd2);

        // Unknown opcode reports the error tag; WRITE shifts without a push.
        pins_before = {spi_cs, spi_sck, spi_mosi};
        base_edge = edge_cnt;
        cmd_q.push_back(16'h07AA);
        exp_q.push_back(16'hFF07);
        wait_res(100);
        wait_idle(100);
        chk("bad_op_pins", {29'd0, spi_cs, spi_sck, spi_mosi}, {29'd0, pins_before});
        chk("bad_op_edges", edge_cnt - base_edge, 32'd0);
        base_edge = edge_cnt; base_push = push_cnt;
        cmd_q.push_back(16'h0355);
        wait_idle(400);
        chk("wr_edges", edge_cnt - base_edge, 32'd16);
        chk("wr_mosi", {24'd0, mosi_sr}, 32'h55);
        chk("wr_no_push", push_cnt - base_push, 32'd0);

        // DELAY of (3+1)*(2+1) clocks plus the FETCH/EXEC overhead, then NOP spacing.
        clk_div = 8'd2;
        base_edge = edge_cnt; base_busy = busy_cnt;
        cmd_q.push_back(16'h0503);
        wait_idle(200);
        chk("dly_busy", busy_cnt - base_busy, 32'd15);
        chk("dly_edges", edge_cnt - base_edge, 32'd0);
        base_pop = pop_cyc.size();
        cmd_q.push_back(16'h0000); cmd_q.push_back(16'h0000); cmd_q.push_back(16'h0000);
        wait_idle(100);
        chk("nop_pops", pop_cyc.size() - base_pop, 32'd3);
        if (pop_cyc.size() - base_pop >= 3) begin
            for (int i = 1; i < 3; i++)
                chk("nop_spacing", (pop_cyc[base_pop + i] - pop_cyc[base_pop + i - 1] >= 3) ? 32'd1 : 32'd0, 32'd1);
        end

        // Reset lands mid-XFER at the fifth SCK edge.
        clk_div = 8'd1;
        base_edge = edge_cnt; base_push = push_cnt;
        cmd_q.push_back(16'h0100); cmd_q.push_back(16'h04F0);
        begin
            int n = 0;
            while ((edge_cnt - base_edge < 5) && (n < 300)) begin
                tick();
                n++;
            end
            chk("rst_reached_edge5", (edge_cnt - base_edge >= 5) ? 32'd1 : 32'd0, 32'd1);
        end
        chk("rst_cs_before", {31'd0, spi_cs}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rst_async", {28'd0, spi_cs, spi_sck, busy, res_shift}, 32'b1000);
        chk("rst_res_data", {16'd0, res_data}, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (40) tick();
        chk("rst_no_push", push_cnt - base_push, 32'd0);
        chk("rst_idle", {30'd0, busy, spi_cs}, 32'b01);

        chk("pop_shift_adjacent", adj_viol, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
